// File: rtl/mkmif_pkg.sv
// Shared constants and FSM encoding for the MKM interface SPI path (23K640 SRAM).
package mkmif_pkg;

   localparam logic [7:0] SPI_CMD_READ  = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
   localparam logic [7:0] SPI_CMD_RDSR  = 8'h05;
   localparam logic [7:0] SPI_CMD_WRSR  = 8'h01;

   // Status register value: sequential mode, HOLD disabled
   localparam logic [7:0] SRAM_STATUS_SEQ = 8'h41;

   localparam int unsigned MIN_SCLK_DIV = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CS_SETUP  = 3'd1,
      ST_SCLK_HIGH = 3'd2,
      ST_SCLK_LOW  = 3'd3,
      ST_CS_HOLD   = 3'd4
   } spi_state_e;

endpackage

// File: rtl/mkmif_clk_div.sv
// Loadable down-counter timing each SPI phase; tick_c marks the last cycle, first_c the first.
module mkmif_clk_div #(
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick_c,
   output logic                 first_c
);

   logic [DIV_WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (load)
         cnt <= div - DIV_WIDTH'(1);
      else if (cnt != '0)
         cnt <= cnt - DIV_WIDTH'(1);
   end

   assign tick_c  = (cnt == '0);
   assign first_c = (cnt == div - DIV_WIDTH'(1));

endmodule

// File: rtl/mkmif_spi.sv
// Byte-oriented mode-0 SPI master for the 23K640 SRAM.
// Optional MKMIF_SPI_LOOPBACK_EN adds a loopback input for bring-up self-test.
module mkmif_spi
   import mkmif_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 7,
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   output logic                   spi_sclk,
   output logic                   spi_cs_n,
   input  logic                   spi_do,
   output logic                   spi_di,
   input  logic                   start,
   input  logic [2:0]             length,
   input  logic [DIV_WIDTH-1:0]   sclk_div,
   input  logic [8*MAX_BYTES-1:0] tx_data,
   output logic [31:0]            rx_data,
`ifdef MKMIF_SPI_LOOPBACK_EN
   input  logic                   loopback,
`endif
   output logic                   ready
);

   localparam int unsigned TX_W  = 8 * MAX_BYTES;
   localparam int unsigned CNT_W = $clog2(TX_W + 1);

   spi_state_e           state_q, state_nxt;
   logic [DIV_WIDTH-1:0] div_q, div_eff_c, div_sel_c;
   logic [TX_W-1:0]      tx_sr;
   logic [31:0]          rx_sr;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 tick_c, first_c, load_c, start_ok_c, rx_in_c, loop_c;
   logic                 sclk_nxt, cs_n_nxt, ready_nxt;

`ifdef MKMIF_SPI_LOOPBACK_EN
   assign loop_c  = loopback;
   assign rx_in_c = loopback ? spi_di : spi_do;
`else
   assign loop_c  = 1'b0;
   assign rx_in_c = spi_do;
`endif

   assign div_eff_c  = (sclk_div < DIV_WIDTH'(MIN_SCLK_DIV)) ? DIV_WIDTH'(MIN_SCLK_DIV) : sclk_div;
   assign start_ok_c = (state_q == ST_IDLE) && start && (length != 3'd0);
   assign div_sel_c  = (state_q == ST_IDLE) ? div_eff_c : div_q;
   assign load_c     = (state_nxt != state_q);

   mkmif_clk_div #(.DIV_WIDTH(DIV_WIDTH)) u_clk_div (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load_c),
      .div     (div_sel_c),
      .tick_c  (tick_c),
      .first_c (first_c)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:      if (start_ok_c) state_nxt = ST_CS_SETUP;
         ST_CS_SETUP:  if (tick_c) state_nxt = ST_SCLK_HIGH;
         ST_SCLK_HIGH: if (tick_c) state_nxt = ST_SCLK_LOW;
         ST_SCLK_LOW:  if (tick_c) state_nxt = (bit_cnt == '0) ? ST_CS_HOLD : ST_SCLK_HIGH;
         ST_CS_HOLD:   if (tick_c) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Pin levels decoded from the state being entered, then registered
   always_comb begin
      sclk_nxt  = 1'b0;
      cs_n_nxt  = 1'b1;
      ready_nxt = 1'b0;
      case (state_nxt)
         ST_IDLE:      ready_nxt = 1'b1;
         ST_CS_SETUP,
         ST_SCLK_LOW:  cs_n_nxt = loop_c;
         ST_SCLK_HIGH: begin
            sclk_nxt = 1'b1;
            cs_n_nxt = loop_c;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spi_sclk <= 1'b0;
         spi_cs_n <= 1'b1;
         ready    <= 1'b1;
      end else begin
         spi_sclk <= sclk_nxt;
         spi_cs_n <= cs_n_nxt;
         ready    <= ready_nxt;
      end
   end

   // Shift registers; tx_sr holds the bits still to be sent after the one on spi_di
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q   <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         bit_cnt <= '0;
         spi_di  <= 1'b0;
         rx_data <= '0;
      end else if (start_ok_c) begin
         div_q   <= div_eff_c;
         tx_sr   <= {tx_data[TX_W-2:0], 1'b0};
         rx_sr   <= '0;
         bit_cnt <= CNT_W'({length, 3'b000});
         spi_di  <= tx_data[TX_W-1];
      end else begin
         case (state_q)
            ST_SCLK_HIGH: begin
               if (first_c)
                  rx_sr <= {rx_sr[30:0], rx_in_c};
               if (tick_c) begin
                  tx_sr   <= {tx_sr[TX_W-2:0], 1'b0};
                  spi_di  <= tx_sr[TX_W-1];
                  bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
            ST_SCLK_LOW:
               if (tick_c && (bit_cnt == '0))
                  spi_di <= 1'b0;
            ST_CS_HOLD:
               if (tick_c)
                  rx_data <= rx_sr;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mkmif_spi.sv
// Self-checking bench for mkmif_spi with a behavioural 23K640 SO model.
module tb_mkmif_spi;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        spi_sclk, spi_cs_n, spi_di, ready;
   logic        spi_do = 1'b0;
   logic        start;
   logic [2:0]  length;
   logic [15:0] sclk_div;
   logic [55:0] tx_data;
   logic [31:0] rx_data;
`ifdef MKMIF_SPI_LOOPBACK_EN
   logic        loopback;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [55:0] resp = '0;
   logic [55:0] di_hist = '0;
   int          edges_total = 0;
   int          edges_base = 0;
   int          cs_falls = 0;

   always #5 clk = ~clk;

   mkmif_spi dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .spi_sclk (spi_sclk),
      .spi_cs_n (spi_cs_n),
      .spi_do   (spi_do),
      .spi_di   (spi_di),
      .start    (start),
      .length   (length),
      .sclk_div (sclk_div),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
`ifdef MKMIF_SPI_LOOPBACK_EN
      .loopback (loopback),
`endif
      .ready    (ready)
   );

   // SRAM SO: next bit presented after each falling SCLK (first bit when CS falls)
   always @(negedge spi_sclk or negedge spi_cs_n) begin
      if (edges_total - edges_base < 56)
         spi_do = resp[55 - (edges_total - edges_base)];
      else
         spi_do = 1'b0;
   end

   always @(posedge spi_sclk) begin
      edges_total = edges_total + 1;
      di_hist     = {di_hist[54:0], spi_di};
   end

   always @(negedge spi_cs_n) cs_falls = cs_falls + 1;

   task automatic run_txn(input int len, input int div, input logic [55:0] tx,
                          input logic [55:0] rsp, input bit lb, input int busy_at,
                          input int chg_at, output int lat);
      int          n, d, exp_lat, falls0;
      logic [55:0] mask, src, tmp, exp_di;
      logic [31:0] rx_snap;
      resp       = rsp;
      edges_base = edges_total;
      falls0     = cs_falls;
      length     = 3'(len);
      sclk_div   = 16'(div);
      tx_data    = tx;
`ifdef MKMIF_SPI_LOOPBACK_EN
      loopback   = lb;
`endif
      @(posedge clk); #1;
      start = 1'b1;
      lat   = -1;
      n     = 0;
      while (n < 5000) begin
         @(posedge clk); #1;
         n++;
         start = (busy_at != 0 && n == busy_at);
         if (n == 1) begin
            vectors++;
            if (spi_cs_n !== lb) begin
               miscompares++;
               $display("FAIL cs_n_after_start: got %b want %b", spi_cs_n, lb);
            end
         end
         if (chg_at != 0 && n == chg_at) sclk_div = 16'd9;
         if (ready === 1'b1) begin
            lat = n;
            break;
         end
      end
      start = 1'b0;
      d       = (div < 2) ? 2 : div;
      exp_lat = 1 + d * (16 * len + 2);
      mask    = (56'd1 << (8 * len)) - 56'd1;
      src     = lb ? tx : rsp;
      tmp     = src >> (56 - 8 * len);
      exp_di  = tx >> (56 - 8 * len);
      vectors++;
      if (lat != exp_lat) begin
         miscompares++;
         $display("FAIL latency len=%0d div=%0d: got %0d want %0d", len, div, lat, exp_lat);
      end
      vectors++;
      if (edges_total - edges_base != 8 * len) begin
         miscompares++;
         $display("FAIL sclk_edges len=%0d: got %0d want %0d", len, edges_total - edges_base, 8 * len);
      end
      vectors++;
      if ((di_hist & mask) !== exp_di) begin
         miscompares++;
         $display("FAIL di_bits len=%0d: got %h want %h", len, di_hist & mask, exp_di);
      end
      vectors++;
      if (rx_data !== tmp[31:0]) begin
         miscompares++;
         $display("FAIL rx_data len=%0d: got %h want %h", len, rx_data, tmp[31:0]);
      end
      vectors++;
      if (cs_falls - falls0 != (lb ? 0 : 1)) begin
         miscompares++;
         $display("FAIL cs_pulses: got %0d want %0d", cs_falls - falls0, lb ? 0 : 1);
      end
      rx_snap = tmp[31:0];
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (rx_data !== rx_snap || ready !== 1'b1 || spi_cs_n !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_stable: rx %h ready %b cs_n %b want rx %h ready 1 cs_n 1",
                  rx_data, ready, spi_cs_n, rx_snap);
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      start    = 1'b0;
      length   = 3'd0;
      sclk_div = 16'd2;
      tx_data  = '0;
`ifdef MKMIF_SPI_LOOPBACK_EN
      loopback = 1'b0;
`endif
      #23;
      vectors++;
      if ({spi_sclk, spi_cs_n, spi_di, ready} !== 4'b0101 || rx_data !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_values: sclk/cs_n/di/ready %b%b%b%b rx %h want 0101 rx 0",
                  spi_sclk, spi_cs_n, spi_di, ready, rx_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_mid();
      int n;
      resp       = 56'hFF << 48;
      edges_base = edges_total;
      length     = 3'd1;
      sclk_div   = 16'd2;
      tx_data    = 56'hA5 << 48;
      @(posedge clk); #1;
      start = 1'b1;
      n = 0;
      while (n < 200 && edges_total - edges_base < 6) begin
         @(posedge clk); #1;
         start = 1'b0;
         n++;
      end
      vectors++;
      if (edges_total - edges_base != 6 || spi_sclk !== 1'b1) begin
         miscompares++;
         $display("FAIL reach_bit5_high: edges %0d sclk %b want 6 1", edges_total - edges_base, spi_sclk);
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({spi_sclk, spi_cs_n, spi_di, ready} !== 4'b0101 || rx_data !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_mid: sclk/cs_n/di/ready %b%b%b%b rx %h want 0101 rx 0",
                  spi_sclk, spi_cs_n, spi_di, ready, rx_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_single();
      int lat;
      run_txn(1, 2, 56'hA5 << 48, 56'h3C << 48, 1'b0, 0, 0, lat);
      vectors++;
      if (lat != 37 || rx_data !== 32'h0000003C) begin
         miscompares++;
         $display("FAIL single_byte: lat %0d rx %h want 37 0000003c", lat, rx_data);
      end
   endtask

   task automatic test_full_read();
      int lat;
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      run_txn(7, 4, {8'h03, 16'h0123, r[31:0]}, {24'h0, 32'hDEADBEEF}, 1'b0, 0, 0, lat);
      vectors++;
      if (lat != 457 || rx_data !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL full_read: lat %0d rx %h want 457 deadbeef", lat, rx_data);
      end
   endtask

   task automatic test_clamp();
      int lat0, lat1, lat2, lat3;
      run_txn(2, 0, 56'h0302 << 40, 56'h5AC3 << 40, 1'b0, 0, 0, lat0);
      run_txn(2, 1, 56'h0302 << 40, 56'h5AC3 << 40, 1'b0, 0, 0, lat1);
      run_txn(2, 2, 56'h0302 << 40, 56'h5AC3 << 40, 1'b0, 0, 0, lat2);
      run_txn(2, 3, 56'h0501 << 40, 56'h0041 << 40, 1'b0, 0, 5, lat3);
      vectors++;
      if (lat0 != lat2 || lat1 != lat2 || lat2 != 69) begin
         miscompares++;
         $display("FAIL clamp_latency: div0 %0d div1 %0d div2 %0d want 69", lat0, lat1, lat2);
      end
   endtask

   task automatic test_busy_and_zero();
      int lat, falls0;
      bit ok;
      run_txn(3, 2, 56'h020000 << 32, 56'h00ABCD << 32, 1'b0, 20, 0, lat);
      falls0 = cs_falls;
      length = 3'd0;
      @(posedge clk); #1;
      start = 1'b1;
      ok = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (ready !== 1'b1 || spi_cs_n !== 1'b1 || spi_sclk !== 1'b0) ok = 1'b0;
      end
      vectors++;
      if (!ok || cs_falls != falls0) begin
         miscompares++;
         $display("FAIL length_zero: ok %0d cs_falls %0d want 1 %0d", ok, cs_falls, falls0);
      end
   endtask

   task automatic test_random();
      int lat;
      logic [63:0] a, b;
      for (int i = 0; i < 6; i++) begin
         a = {$urandom(), $urandom()};
         b = {$urandom(), $urandom()};
         run_txn(int'($urandom_range(1, 7)), int'($urandom_range(0, 5)), a[55:0], b[55:0],
                 1'b0, 0, 0, lat);
      end
   endtask

`ifdef MKMIF_SPI_LOOPBACK_EN
   task automatic test_loopback();
      int lat;
      logic [63:0] b;
      b = {$urandom(), $urandom()};
      run_txn(4, 3, {32'h12345678, 24'h0}, b[55:0], 1'b1, 0, 0, lat);
      vectors++;
      if (rx_data !== 32'h12345678) begin
         miscompares++;
         $display("FAIL loopback_rx: got %h want 12345678", rx_data);
      end
      loopback = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid();
      test_single();
      test_full_read();
      test_clamp();
      test_busy_and_zero();
      test_random();
`ifdef MKMIF_SPI_LOOPBACK_EN
      test_loopback();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
